// File: rtl/picorv32_mem_model_if.sv
// picorv32 native memory bus (mem_valid/mem_ready handshake).
// master = core side, slave = memory side.
interface picorv32_mem_model_if;
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/picorv32_mem_model.sv
// picorv32_mem_model: single-port memory slave for the picorv32 native bus.
// Serves fetches, loads and stores with LATENCY wait states, counts fetch/data
// handshakes and records the last fetched PC.
// Optional macro MEM_BOUND_CHK_EN: out-of-range reads return EBREAK, writes are
// dropped and err becomes sticky; without it the word index wraps and err is 0.
module picorv32_mem_model #(
    parameter int unsigned DEPTH_WORDS  = 1024,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int unsigned LATENCY      = 1,
    parameter logic [31:0] DEFAULT_WORD = 32'h0000_0013,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                clk,
    input  logic                resetn,
    picorv32_mem_model_if.slave bus,
    output logic [CNT_W-1:0]    fetch_count,
    output logic [CNT_W-1:0]    data_count,
    output logic [31:0]         last_fetch_pc,
    output logic                err
);
    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    // Words are stored XOR DEFAULT_WORD so never-written (zero) storage reads as DEFAULT_WORD
    logic [31:0] mem_q [DEPTH_WORDS];

    // Handshake qualifier and the request attributes it applies to
    logic        hs_c;
    logic        hs_instr_c;
    logic [31:0] hs_addr_c;
    logic [31:0] hs_wdata_c;
    logic [3:0]  hs_wstrb_c;
    logic        wr_en_c;

    function automatic logic [AW-1:0] word_idx(input logic [31:0] addr);
        return AW'((addr - BASE_ADDR) >> 2);
    endfunction

`ifdef MEM_BOUND_CHK_EN
    localparam logic [31:0] EBREAK_WORD = 32'h0010_0073;

    function automatic logic in_range(input logic [31:0] addr);
        return ((addr - BASE_ADDR) >> (AW + 2)) == 32'd0;
    endfunction

    function automatic logic [31:0] read_word(input logic [31:0] addr);
        if (!in_range(addr)) begin
            return EBREAK_WORD;
        end
        return mem_q[word_idx(addr)] ^ DEFAULT_WORD;
    endfunction

    assign wr_en_c = hs_c && (hs_wstrb_c != 4'd0) && in_range(hs_addr_c);
`else
    function automatic logic [31:0] read_word(input logic [31:0] addr);
        return mem_q[word_idx(addr)] ^ DEFAULT_WORD;
    endfunction

    assign wr_en_c = hs_c && (hs_wstrb_c != 4'd0);
`endif

    // Byte-masked store on the handshake edge
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            for (int b = 0; b < 4; b++) begin
                if (hs_wstrb_c[b]) begin
                    mem_q[word_idx(hs_addr_c)][8*b +: 8] <= hs_wdata_c[8*b +: 8] ^ DEFAULT_WORD[8*b +: 8];
                end
            end
        end
    end

    // Saturating handshake counters and last fetched PC
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fetch_count   <= '0;
            data_count    <= '0;
            last_fetch_pc <= '0;
        end else if (hs_c) begin
            if (hs_instr_c) begin
                if (fetch_count != '1) begin
                    fetch_count <= fetch_count + CNT_W'(1);
                end
                last_fetch_pc <= hs_addr_c;
            end else if (data_count != '1) begin
                data_count <= data_count + CNT_W'(1);
            end
        end
    end

`ifdef MEM_BOUND_CHK_EN
    // Sticky flag for any handshake outside the array
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            err <= 1'b0;
        end else if (hs_c && !in_range(hs_addr_c)) begin
            err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

    if (LATENCY == 0) begin : g_comb
        // Zero wait states: ready follows valid, data is an asynchronous read
        assign hs_c          = bus.mem_valid & resetn;
        assign hs_instr_c    = bus.mem_instr;
        assign hs_addr_c     = bus.mem_addr;
        assign hs_wdata_c    = bus.mem_wdata;
        assign hs_wstrb_c    = bus.mem_wstrb;
        assign bus.mem_ready = hs_c;
        assign bus.mem_rdata = hs_c ? read_word(bus.mem_addr) : 32'd0;
    end else begin : g_fsm
        localparam logic [1:0] S_IDLE = 2'd0;
        localparam logic [1:0] S_WAIT = 2'd1;
        localparam logic [1:0] S_RESP = 2'd2;

        logic [1:0]  state_q, state_d;
        logic [3:0]  wait_q, wait_d;
        logic        cap_en_c;
        logic        cap_instr_q;
        logic [31:0] cap_addr_q;
        logic [31:0] cap_wdata_q;
        logic [3:0]  cap_wstrb_q;
        logic [31:0] rsp_addr_c;
        logic [3:0]  rsp_wstrb_c;
        logic [31:0] rsp_data_c;
        logic        ready_q;
        logic [31:0] rdata_q;

        // Next state: accept in IDLE, count wait states while valid holds, respond once
        always_comb begin
            state_d  = state_q;
            wait_d   = wait_q;
            cap_en_c = 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.mem_valid) begin
                        cap_en_c = 1'b1;
                        wait_d   = 4'(LATENCY - 1);
                        state_d  = (LATENCY == 1) ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!bus.mem_valid) begin
                        state_d = S_IDLE;
                    end else begin
                        wait_d = wait_q - 4'd1;
                        if (wait_q == 4'd1) begin
                            state_d = S_RESP;
                        end
                    end
                end
                S_RESP: state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end

        // Response word: the live request when jumping from IDLE, else the captured one
        always_comb begin
            rsp_addr_c  = (state_q == S_IDLE) ? bus.mem_addr  : cap_addr_q;
            rsp_wstrb_c = (state_q == S_IDLE) ? bus.mem_wstrb : cap_wstrb_q;
            rsp_data_c  = (rsp_wstrb_c != 4'd0) ? 32'd0 : read_word(rsp_addr_c);
        end

        // State, capture and registered response outputs
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                state_q     <= S_IDLE;
                wait_q      <= '0;
                cap_instr_q <= 1'b0;
                cap_addr_q  <= '0;
                cap_wdata_q <= '0;
                cap_wstrb_q <= '0;
                ready_q     <= 1'b0;
                rdata_q     <= '0;
            end else begin
                state_q <= state_d;
                wait_q  <= wait_d;
                if (cap_en_c) begin
                    cap_instr_q <= bus.mem_instr;
                    cap_addr_q  <= bus.mem_addr;
                    cap_wdata_q <= bus.mem_wdata;
                    cap_wstrb_q <= bus.mem_wstrb;
                end
                ready_q <= (state_d == S_RESP);
                if (state_d == S_RESP) begin
                    rdata_q <= rsp_data_c;
                end
            end
        end

        assign hs_c          = ready_q & bus.mem_valid;
        assign hs_instr_c    = cap_instr_q;
        assign hs_addr_c     = cap_addr_q;
        assign hs_wdata_c    = cap_wdata_q;
        assign hs_wstrb_c    = cap_wstrb_q;
        assign bus.mem_ready = ready_q;
        assign bus.mem_rdata = rdata_q;
    end

endmodule

// File: tb/tb_picorv32_mem_model.sv
// Bench for picorv32_mem_model: three instances (LATENCY 0/1/3, different depths,
// bases and counter widths) driven by directed and random transfers and checked
// against a word-addressed associative-array model of the memory.
module tb_picorv32_mem_model;
    localparam int unsigned ND     = 3;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] EBREAK = 32'h0010_0073;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    logic [ND-1:0]       valid_i, instr_i, ready_o, err_o;
    logic [ND-1:0][31:0] addr_i, wdata_i, rdata_o, lpc_o;
    logic [ND-1:0][3:0]  wstrb_i;
    logic [ND-1:0][15:0] fcnt_o, dcnt_o;

    int vectors     = 0;
    int miscompares = 0;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        localparam int unsigned LAT  = (g == 0) ? 0 : (g == 1) ? 1 : 3;
        localparam int unsigned DEP  = (g == 0) ? 16 : (g == 1) ? 64 : 1024;
        localparam int unsigned CW   = (g == 0) ? 4 : 16;
        localparam logic [31:0] BASE = (g == 1) ? 32'h0000_1000 : 32'h0000_0000;

        logic [CW-1:0] fc, dc;
        picorv32_mem_model_if bus ();

        assign bus.mem_valid = valid_i[g];
        assign bus.mem_instr = instr_i[g];
        assign bus.mem_addr  = addr_i[g];
        assign bus.mem_wdata = wdata_i[g];
        assign bus.mem_wstrb = wstrb_i[g];
        assign ready_o[g]    = bus.mem_ready;
        assign rdata_o[g]    = bus.mem_rdata;
        assign fcnt_o[g]     = 16'(fc);
        assign dcnt_o[g]     = 16'(dc);

        picorv32_mem_model #(
            .DEPTH_WORDS (DEP),
            .BASE_ADDR   (BASE),
            .LATENCY     (LAT),
            .DEFAULT_WORD(NOP),
            .CNT_W       (CW)
        ) u_dut (
            .clk          (clk),
            .resetn       (resetn),
            .bus          (bus),
            .fetch_count  (fc),
            .data_count   (dc),
            .last_fetch_pc(lpc_o[g]),
            .err          (err_o[g])
        );
    end

    // ---------------- reference model ----------------
    logic [31:0] mdl_mem [longint];
    int          mdl_fc  [ND];
    int          mdl_dc  [ND];
    logic [31:0] mdl_pc  [ND];
    logic        mdl_err [ND];

    function automatic int unsigned m_depth(input int d);
        return (d == 0) ? 16 : (d == 1) ? 64 : 1024;
    endfunction

    function automatic logic [31:0] m_base(input int d);
        return (d == 1) ? 32'h0000_1000 : 32'h0000_0000;
    endfunction

    function automatic int m_lat(input int d);
        return (d == 0) ? 0 : (d == 1) ? 1 : 3;
    endfunction

    function automatic logic [15:0] sat(input int d, input int n);
        int mx;
        mx = (d == 0) ? 15 : 65535;
        return 16'((n > mx) ? mx : n);
    endfunction

    function automatic logic m_oob(input int d, input logic [31:0] addr);
        logic [31:0] w;
        w = (addr - m_base(d)) / 4;
        return w >= m_depth(d);
    endfunction

    function automatic longint m_key(input int d, input logic [31:0] addr);
        logic [31:0] w;
        w = ((addr - m_base(d)) / 4) % m_depth(d);
        return longint'(d) * 64'h1_0000_0000 + longint'(w);
    endfunction

    function automatic logic [31:0] mdl_read(input int d, input logic [31:0] addr);
        longint k;
`ifdef MEM_BOUND_CHK_EN
        if (m_oob(d, addr)) return EBREAK;
`endif
        k = m_key(d, addr);
        return mdl_mem.exists(k) ? mdl_mem[k] : NOP;
    endfunction

    function automatic void mdl_handshake(input int d, input logic instr, input logic [31:0] addr,
                                          input logic [31:0] wdata, input logic [3:0] wstrb);
        logic [31:0] v;
        if (instr) begin
            mdl_fc[d]++;
            mdl_pc[d] = addr;
        end else begin
            mdl_dc[d]++;
        end
        if (m_oob(d, addr)) begin
`ifdef MEM_BOUND_CHK_EN
            mdl_err[d] = 1'b1;
            return;
`endif
        end
        if (wstrb != 4'd0) begin
            v = mdl_read(d, addr);
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) v[8*b +: 8] = wdata[8*b +: 8];
            end
            mdl_mem[m_key(d, addr)] = v;
        end
    endfunction

    function automatic void mdl_reset();
        for (int d = 0; d < ND; d++) begin
            mdl_fc[d]  = 0;
            mdl_dc[d]  = 0;
            mdl_pc[d]  = '0;
            mdl_err[d] = 1'b0;
        end
    endfunction

    // One core transfer on instance d; starts and ends just after a rising edge
    task automatic xfer(input int d, input logic instr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wstrb, output logic [31:0] rd, output int lat);
        valid_i[d] = 1'b1;
        instr_i[d] = instr;
        addr_i[d]  = addr;
        wdata_i[d] = wdata;
        wstrb_i[d] = wstrb;
        lat = -1;
        rd  = '0;
        for (int c = 0; c < 32; c++) begin
            @(negedge clk);
            if (ready_o[d] === 1'b1) begin
                lat = c;
                rd  = rdata_o[d];
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        valid_i[d] = 1'b0;
        instr_i[d] = 1'b0;
        wstrb_i[d] = 4'd0;
        if (lat >= 0) mdl_handshake(d, instr, addr, wdata, wstrb);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        resetn = 1'b0;
        mdl_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            vectors++;
            if (ready_o[d] !== 1'b0) begin miscompares++; $display("FAIL reset_ready[%0d]: got %b want 0", d, ready_o[d]); end
            vectors++;
            if (rdata_o[d] !== 32'd0) begin miscompares++; $display("FAIL reset_rdata[%0d]: got %h want 0", d, rdata_o[d]); end
            vectors++;
            if (fcnt_o[d] !== 16'd0 || dcnt_o[d] !== 16'd0) begin
                miscompares++; $display("FAIL reset_counts[%0d]: got %h/%h want 0/0", d, fcnt_o[d], dcnt_o[d]);
            end
            vectors++;
            if (lpc_o[d] !== 32'd0 || err_o[d] !== 1'b0) begin
                miscompares++; $display("FAIL reset_pc_err[%0d]: got %h/%b want 0/0", d, lpc_o[d], err_o[d]);
            end
        end
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_fetch_stream();
        logic [31:0] pc, rd;
        int lat;
        for (int i = 0; i < 12; i++) begin
            pc = 32'(i * 4);
            xfer(0, 1'b1, pc, 32'd0, 4'd0, rd, lat);
            vectors++;
            if (lat !== 0) begin miscompares++; $display("FAIL stream_lat[%0d]: got %0d want 0", i, lat); end
            vectors++;
            if (rd !== NOP) begin miscompares++; $display("FAIL stream_rdata[%0d]: got %h want %h", i, rd, NOP); end
            vectors++;
            if (fcnt_o[0] !== sat(0, i + 1)) begin
                miscompares++; $display("FAIL stream_fcnt[%0d]: got %h want %h", i, fcnt_o[0], sat(0, i + 1));
            end
            vectors++;
            if (lpc_o[0] !== pc) begin miscompares++; $display("FAIL stream_pc[%0d]: got %h want %h", i, lpc_o[0], pc); end
        end
        @(negedge clk);
        vectors++;
        if (ready_o[0] !== 1'b0 || rdata_o[0] !== 32'd0) begin
            miscompares++; $display("FAIL stream_idle: got ready %b rdata %h want 0/0", ready_o[0], rdata_o[0]);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_latency();
        logic [31:0] rd;
        int lat;
        xfer(2, 1'b1, 32'h0000_0010, 32'd0, 4'd0, rd, lat);
        vectors++;
        if (lat !== 3) begin miscompares++; $display("FAIL lat3_latency: got %0d want 3", lat); end
        vectors++;
        if (rd !== NOP) begin miscompares++; $display("FAIL lat3_rdata: got %h want %h", rd, NOP); end
        vectors++;
        if (fcnt_o[2] !== 16'd1) begin miscompares++; $display("FAIL lat3_fcnt: got %h want 1", fcnt_o[2]); end
        vectors++;
        if (lpc_o[2] !== 32'h10) begin miscompares++; $display("FAIL lat3_pc: got %h want 10", lpc_o[2]); end
        @(negedge clk);
        vectors++;
        if (ready_o[2] !== 1'b0) begin miscompares++; $display("FAIL lat3_pulse: got %b want 0", ready_o[2]); end
        repeat (3) @(negedge clk);
        vectors++;
        if (rdata_o[2] !== NOP) begin miscompares++; $display("FAIL lat3_hold: got %h want %h", rdata_o[2], NOP); end
        @(posedge clk); #1;
        xfer(1, 1'b1, 32'h0000_1008, 32'd0, 4'd0, rd, lat);
        vectors++;
        if (lat !== 1 || rd !== NOP) begin
            miscompares++; $display("FAIL lat1_fetch: got lat %0d rdata %h want 1/%h", lat, rd, NOP);
        end
    endtask

    task automatic test_byte_store();
        logic [31:0] rd;
        int lat;
        xfer(2, 1'b0, 32'h0000_0020, 32'hDEAD_BEEF, 4'b0110, rd, lat);
        vectors++;
        if (lat !== 3 || rd !== 32'd0) begin
            miscompares++; $display("FAIL bstore_resp: got lat %0d rdata %h want 3/0", lat, rd);
        end
        xfer(2, 1'b0, 32'h0000_0020, 32'd0, 4'd0, rd, lat);
        vectors++;
        if (rd !== 32'h00AD_BE13) begin miscompares++; $display("FAIL bstore_load: got %h want 00adbe13", rd); end
        vectors++;
        if (dcnt_o[2] !== 16'd2) begin miscompares++; $display("FAIL bstore_dcnt: got %h want 2", dcnt_o[2]); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd, a, exp;
        int lat;
        for (int d = 0; d < ND; d++) begin
            for (int i = 0; i < 3; i++) begin
                a = m_base(d) + 32'($urandom_range(0, m_depth(d) - 1) * 4);
                xfer(d, 1'b0, a, $urandom, 4'($urandom_range(1, 15)), rd, lat);
                exp = mdl_read(d, a);
                xfer(d, 1'b0, a, 32'd0, 4'd0, rd, lat);
                vectors++;
                if (rd !== exp || lat !== m_lat(d)) begin
                    miscompares++;
                    $display("FAIL b2b[%0d]: addr %h got %h lat %0d want %h lat %0d", d, a, rd, lat, exp, m_lat(d));
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        int lat;
        valid_i[2] = 1'b1;
        instr_i[2] = 1'b0;
        addr_i[2]  = 32'h0000_0040;
        wdata_i[2] = 32'hCAFE_F00D;
        wstrb_i[2] = 4'hF;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            vectors++;
            if (ready_o[2] !== 1'b0) begin miscompares++; $display("FAIL rmid_early[%0d]: got %b want 0", c, ready_o[2]); end
            @(posedge clk); #1;
        end
        resetn = 1'b0;
        mdl_reset();
        @(negedge clk);
        vectors++;
        if (ready_o[2] !== 1'b0 || rdata_o[2] !== 32'd0) begin
            miscompares++; $display("FAIL rmid_bus: got ready %b rdata %h want 0/0", ready_o[2], rdata_o[2]);
        end
        vectors++;
        if (fcnt_o[2] !== 16'd0 || dcnt_o[2] !== 16'd0 || lpc_o[2] !== 32'd0 || err_o[2] !== 1'b0) begin
            miscompares++; $display("FAIL rmid_state: got %h/%h/%h/%b want all 0", fcnt_o[2], dcnt_o[2], lpc_o[2], err_o[2]);
        end
        valid_i[2] = 1'b0;
        wstrb_i[2] = 4'd0;
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;
        xfer(2, 1'b0, 32'h0000_0040, 32'd0, 4'd0, rd, lat);
        vectors++;
        if (rd !== NOP || lat !== 3) begin
            miscompares++; $display("FAIL rmid_read: got %h lat %0d want %h lat 3", rd, lat, NOP);
        end
    endtask

    task automatic test_saturate();
        logic [31:0] rd;
        int lat;
        for (int i = 0; i < 20; i++) begin
            xfer(0, 1'b1, 32'($urandom_range(0, 15) * 4), 32'd0, 4'd0, rd, lat);
            vectors++;
            if (fcnt_o[0] !== sat(0, i + 1)) begin
                miscompares++; $display("FAIL sat_fcnt[%0d]: got %h want %h", i, fcnt_o[0], sat(0, i + 1));
            end
        end
        vectors++;
        if (fcnt_o[0] !== 16'h000F || dcnt_o[0] !== 16'd0) begin
            miscompares++; $display("FAIL sat_final: got %h/%h want f/0", fcnt_o[0], dcnt_o[0]);
        end
    endtask

    task automatic test_bound();
        logic [31:0] rd, exp;
        logic        e_err;
        int lat;
`ifdef MEM_BOUND_CHK_EN
        e_err = 1'b1;
`else
        e_err = 1'b0;
`endif
        exp = mdl_read(0, 32'h44);
        xfer(0, 1'b1, 32'h0000_0044, 32'd0, 4'd0, rd, lat);
        vectors++;
        if (rd !== exp) begin miscompares++; $display("FAIL bound_fetch: got %h want %h", rd, exp); end
        vectors++;
        if (err_o[0] !== e_err) begin miscompares++; $display("FAIL bound_err: got %b want %b", err_o[0], e_err); end
        xfer(0, 1'b0, 32'h0000_0044, 32'h1234_5678, 4'hF, rd, lat);
        exp = mdl_read(0, 32'h04);
        xfer(0, 1'b0, 32'h0000_0004, 32'd0, 4'd0, rd, lat);
        vectors++;
        if (rd !== exp) begin miscompares++; $display("FAIL bound_store: got %h want %h", rd, exp); end
        vectors++;
        if (err_o[0] !== e_err) begin miscompares++; $display("FAIL bound_sticky: got %b want %b", err_o[0], e_err); end
    endtask

    task automatic test_random();
        logic [31:0] rd, a, exp;
        logic [3:0]  ws;
        logic        ins, seen;
        int d, lat, k, n;
        for (int i = 0; i < 150; i++) begin
            d = int'($urandom_range(0, ND - 1));
            a = m_base(d) - 32'd16 + 32'($urandom_range(0, m_depth(d) + 20) * 4) + 32'($urandom_range(0, 3));
            k = int'($urandom_range(0, 3));
            ins = (k == 0);
            ws  = (k >= 2) ? 4'($urandom_range(1, 15)) : 4'd0;
            if (d == 2 && $urandom_range(0, 4) == 0) begin
                valid_i[2] = 1'b1; instr_i[2] = 1'b0; addr_i[2] = a; wdata_i[2] = $urandom; wstrb_i[2] = 4'hF;
                n = int'($urandom_range(1, 2));
                seen = 1'b0;
                repeat (n) begin
                    @(negedge clk);
                    if (ready_o[2] !== 1'b0) seen = 1'b1;
                    @(posedge clk); #1;
                end
                valid_i[2] = 1'b0;
                wstrb_i[2] = 4'd0;
                @(posedge clk); #1;
                vectors++;
                if (seen !== 1'b0 || dcnt_o[2] !== sat(2, mdl_dc[2])) begin
                    miscompares++; $display("FAIL rnd_abort[%0d]: ready seen %b dcnt %h want 0/%h", i, seen, dcnt_o[2], sat(2, mdl_dc[2]));
                end
            end else begin
                exp = (ws != 4'd0) ? 32'd0 : mdl_read(d, a);
                xfer(d, ins, a, $urandom, ws, rd, lat);
                vectors++;
                if (lat !== m_lat(d)) begin miscompares++; $display("FAIL rnd_lat[%0d]: dut %0d got %0d want %0d", i, d, lat, m_lat(d)); end
                if (!(d == 0 && ws != 4'd0)) begin
                    vectors++;
                    if (rd !== exp) begin miscompares++; $display("FAIL rnd_rdata[%0d]: dut %0d addr %h got %h want %h", i, d, a, rd, exp); end
                end
                vectors++;
                if (fcnt_o[d] !== sat(d, mdl_fc[d]) || dcnt_o[d] !== sat(d, mdl_dc[d])) begin
                    miscompares++; $display("FAIL rnd_counts[%0d]: dut %0d got %h/%h want %h/%h", i, d,
                                            fcnt_o[d], dcnt_o[d], sat(d, mdl_fc[d]), sat(d, mdl_dc[d]));
                end
                vectors++;
                if (lpc_o[d] !== mdl_pc[d] || err_o[d] !== mdl_err[d]) begin
                    miscompares++; $display("FAIL rnd_pc_err[%0d]: dut %0d got %h/%b want %h/%b", i, d,
                                            lpc_o[d], err_o[d], mdl_pc[d], mdl_err[d]);
                end
            end
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        resetn  = 1'b0;
        valid_i = '0;
        instr_i = '0;
        addr_i  = '0;
        wdata_i = '0;
        wstrb_i = '0;
        test_reset();
        test_fetch_stream();
        test_latency();
        test_byte_store();
        test_back_to_back();
        test_reset_mid();
        test_saturate();
        test_bound();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
